// File: rtl/io_console_ctrl.sv
// Console/power-off sequencer between the core's MMIO store port and the simulation io device.
// Console bytes are queued in a FIFO and paced out; power-off is issued only after the queue drains.
module io_console_ctrl #(
   parameter int DEPTH       = 4,
   parameter int PACE_CYCLES = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [31:0]              cpu_wdata,
   input  logic                     cpu_addr,
   input  logic                     cpu_we,
   output logic                     cpu_stall,
   output logic [31:0]              io_data,
   output logic                     io_addr,
   output logic                     io_we,
   output logic [$clog2(DEPTH):0]   fifo_level,
   output logic                     halted
);

   localparam int AW = $clog2(DEPTH);
   localparam int PW = (PACE_CYCLES > 1) ? $clog2(PACE_CYCLES) : 1;

   typedef enum logic [1:0] {RUN, DRAIN, POWER, HALTED} state_t;

   state_t        r_state;
   logic [7:0]    r_mem [DEPTH];
   logic [AW-1:0] r_wrPtr;
   logic [AW-1:0] r_rdPtr;
   logic [AW:0]   r_count;
   logic [PW-1:0] r_paceCnt;

   logic w_full;
   logic w_empty;
   logic w_paceZero;
   logic w_accept;
   logic w_push;
   logic w_pop;

   // Fullness is the start-of-cycle value, so a pop never frees a slot for the same cycle's push.
   assign w_full     = (r_count == (AW+1)'(DEPTH));
   assign w_empty    = (r_count == '0);
   assign w_paceZero = (r_paceCnt == '0);
   assign cpu_stall  = cpu_we & ((r_state != RUN) | w_full);
   assign w_accept   = cpu_we & ~cpu_stall;
   assign w_push     = w_accept & ~cpu_addr;
   assign w_pop      = ((r_state == RUN) || (r_state == DRAIN)) && !w_empty && w_paceZero;
   assign fifo_level = r_count;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state   <= RUN;
         r_wrPtr   <= '0;
         r_rdPtr   <= '0;
         r_count   <= '0;
         r_paceCnt <= '0;
         io_we     <= 1'b0;
         io_addr   <= 1'b0;
         io_data   <= '0;
         halted    <= 1'b0;
      end else begin
         io_we <= 1'b0;

         if (w_push) begin
            r_mem[r_wrPtr] <= cpu_wdata[7:0];
            r_wrPtr        <= r_wrPtr + 1'b1;
         end

         if (w_pop) begin
            r_rdPtr   <= r_rdPtr + 1'b1;
            io_we     <= 1'b1;
            io_addr   <= 1'b0;
            io_data   <= {24'b0, r_mem[r_rdPtr]};
            r_paceCnt <= PW'(PACE_CYCLES - 1);
         end else if (!w_paceZero) begin
            r_paceCnt <= r_paceCnt - 1'b1;
         end

         if (w_push && !w_pop) begin
            r_count <= r_count + 1'b1;
         end else if (!w_push && w_pop) begin
            r_count <= r_count - 1'b1;
         end

         // Power-off waits for an empty queue and an expired pace window, keeping the char->power gap.
         case (r_state)
            RUN: begin
               if (w_accept && cpu_addr) begin
                  r_state <= DRAIN;
               end
            end
            DRAIN: begin
               if (w_empty && w_paceZero) begin
                  r_state <= POWER;
                  io_we   <= 1'b1;
                  io_addr <= 1'b1;
                  io_data <= '0;
               end
            end
            POWER: begin
               r_state <= HALTED;
               halted  <= 1'b1;
            end
            HALTED: begin
               r_state <= HALTED;
            end
            default: begin
               r_state <= RUN;
            end
         endcase
      end
   end

endmodule
